trace_streamer: RTL

Hardware commit-trace transmitter for the pipelined CPU. Each cycle it samples the writeback register-write port, the memory-stage load/store port and the halt signal, packs any activity into a record, buffers records in a FIFO, and serializes them as 16-bit words over a valid/ready stream. It is the on-chip source of the REG/LOAD/STORE/halt event trace consumed off-chip or by a bench-side decoder.

---
 rtl/trace_streamer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_streamer.sv
// Commit-trace transmitter: packs writeback/memory/halt activity into records,
// queues them in a FIFO and serializes each record as 1..4 16-bit stream words.
module trace_streamer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        reg_we,
    input  logic [3:0]  reg_addr,
    input  logic [15:0] reg_data,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_last,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        r;
        logic        l;
        logic        s;
        logic        h;
        logic [3:0]  raddr;
        logic        drop;
        logic [6:0]  ts;
        logic [15:0] rdata;
        logic [15:0] maddr;
        logic [15:0] mval;
    } rec_t;

    typedef enum logic [1:0] {HDR, REGD, ADDR, DATA} word_e;

    function automatic logic [15:0] hdr_word(input rec_t rec);
        return {rec.r, rec.l, rec.s, rec.h, rec.raddr, rec.drop, rec.ts};
    endfunction

    rec_t        mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [15:0]   cyc_r;
    logic          halted_r;
    logic          drop_pend_r;
    logic          overflow_r;
    logic [7:0]    drop_cnt_r;
    word_e         idx_r;
    word_e         idx_s;
    word_e         nxt_s;

    rec_t        new_rec_s;
    rec_t        head_s;
    logic        event_s;
    logic        empty_s;
    logic        full_s;
    logic        push_s;
    logic        drop_s;
    logic        pop_s;
    logic        last_s;
    logic [15:0] word_s;
    logic        cyc_unused_s;

    // Upper counter bits only exist so the counter wraps at 16 bits.
    assign cyc_unused_s = ^cyc_r[15:7];

    assign event_s = en & ~halted_r & (reg_we | mem_re | mem_we | halt);
    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == (AW+1)'(DEPTH));
    assign head_s  = mem_r[rd_ptr_r];
    assign pop_s   = ~empty_s & tx_ready & last_s;
    assign push_s  = event_s & (~full_s | pop_s);
    assign drop_s  = event_s & ~push_s;

    // Assemble the record for this cycle's activity; store beats load.
    always_comb begin
        new_rec_s       = '0;
        new_rec_s.r     = reg_we;
        new_rec_s.s     = mem_we;
        new_rec_s.l     = mem_re & ~mem_we;
        new_rec_s.h     = halt;
        new_rec_s.raddr = reg_we ? reg_addr : 4'd0;
        new_rec_s.drop  = drop_pend_r;
        new_rec_s.ts    = cyc_r[6:0];
        new_rec_s.rdata = reg_data;
        new_rec_s.maddr = mem_addr;
        new_rec_s.mval  = mem_we ? mem_wdata : mem_rdata;
    end

    // Word-index FSM: select the current word and the one that follows it.
    always_comb begin
        nxt_s  = HDR;
        last_s = 1'b0;
        word_s = 16'd0;
        case (idx_r)
            HDR: begin
                word_s = hdr_word(head_s);
                if (head_s.r) begin
                    nxt_s = REGD;
                end else if (head_s.l | head_s.s) begin
                    nxt_s = ADDR;
                end else begin
                    last_s = 1'b1;
                end
            end
            REGD: begin
                word_s = head_s.rdata;
                if (head_s.l | head_s.s) begin
                    nxt_s = ADDR;
                end else begin
                    last_s = 1'b1;
                end
            end
            ADDR: begin
                word_s = head_s.maddr;
                nxt_s  = DATA;
            end
            DATA: begin
                word_s = head_s.mval;
                last_s = 1'b1;
            end
            default: begin
                nxt_s = HDR;
            end
        endcase
        if (!empty_s && tx_ready) begin
            idx_s = nxt_s;
        end else begin
            idx_s = idx_r;
        end
    end

    // Word-index state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r <= HDR;
        end else begin
            idx_r <= idx_s;
        end
    end

    // Record storage; stale entries beyond the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= new_rec_s;
        end
    end

    // FIFO pointers, cycle counter, halt latch and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            cyc_r       <= 16'd0;
            halted_r    <= 1'b0;
            drop_pend_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            cyc_r <= cyc_r + 16'd1;
            if (push_s) begin
                wr_ptr_r    <= wr_ptr_r + AW'(1);
                drop_pend_r <= 1'b0;
                if (new_rec_s.h) begin
                    halted_r <= 1'b1;
                end
            end else if (drop_s) begin
                drop_pend_r <= 1'b1;
                overflow_r  <= 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign tx_valid   = ~empty_s;
    assign tx_data    = empty_s ? 16'd0 : word_s;
    assign tx_last    = ~empty_s & last_s;
    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;
    assign done       = halted_r & empty_s;

endmodule
